block_mem_responder: RTL and testbench
======================================

BLOCK_MEM_RESPONDER -- requirements
Module: block_mem_responder

Interface
REQ-001 The block SHALL have parameter BLOCK_SIZE, default 16: bytes per block; data width = BLOCK_SIZE*8.
REQ-002 The block SHALL have parameter NUM_BLOCKS, default 256: storage depth in blocks, power of two.
REQ-003 The block SHALL have parameter DELAY, default 50: access latency in cycles, legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port is_input_valid, input, 1 bit: requester presents a request.
REQ-007 The block SHALL have port addr, input, 32 bits: block index, already byte address >> CLOG2(BLOCK_SIZE).
REQ-008 The block SHALL have port mem_read, input, 1 bit: read request.
REQ-009 The block SHALL have port mem_write, input, 1 bit: write request.
REQ-010 The block SHALL have port din, input, BLOCK_SIZE*8 bits: write block data.
REQ-011 The block SHALL have port is_output_valid, output, 1 bit: read data valid, one-cycle pulse.
REQ-012 The block SHALL have port dout, output, BLOCK_SIZE*8 bits: read block data.
REQ-013 The block SHALL have port mem_ready, output, 1 bit: block can accept a request this cycle.

Function
REQ-014 The block SHALL implement states IDLE, BUSY and RESP; mem_ready SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted at an edge where the state is IDLE, is_input_valid=1 and exactly one of mem_read or mem_write is 1.
REQ-016 At acceptance the block SHALL latch addr[CLOG2(NUM_BLOCKS)-1:0], din and the request type, load the counter with DELAY-1, and go to BUSY.
REQ-017 Upper addr bits SHALL be ignored, so the index wraps modulo NUM_BLOCKS.
REQ-018 is_input_valid with both mem_read and mem_write at 1, or with neither, SHALL be ignored; the block SHALL stay in IDLE.
REQ-019 Inputs SHALL be ignored in BUSY and RESP; only latched values are used.
REQ-020 In BUSY the counter SHALL decrement each cycle; at count 0 the block SHALL go to RESP, so RESP is entered DELAY edges after acceptance.
REQ-021 In RESP for a write, the block SHALL commit the latched din to the latched index at that edge, then return to IDLE.
REQ-022 In RESP for a read, the block SHALL drive is_output_valid=1 and dout=stored block for exactly that cycle, then return to IDLE.
REQ-023 dout SHALL hold its last read value until the next read response.
REQ-024 is_output_valid SHALL never be 1 for a write.
REQ-025 Acceptance-to-ready: mem_ready SHALL be 0 for DELAY+1 cycles after the accepting edge, then return to 1.
REQ-026 A read of an index written earlier SHALL return the committed data; back-to-back same-index write then read SHALL return the new data.
REQ-027 A request held after the response SHALL be accepted again as a new request; the requester owns deasserting it.

Reset
REQ-028 While reset=1 at an edge, the block SHALL set state=IDLE, counter=0, is_output_valid=0, dout=0 and mem_ready=1.
REQ-029 Reset mid-operation SHALL abort the pending request: no write commit and no is_output_valid pulse.
REQ-030 A request SHALL be acceptable at the first edge after reset deasserts.

Configuration
REQ-031 The block SHALL support macro BLOCK_MEM_ZERO_INIT_EN.
REQ-032 With BLOCK_MEM_ZERO_INIT_EN defined, reset SHALL clear every storage block to 0 in the same edge.
REQ-033 Without BLOCK_MEM_ZERO_INIT_EN, storage contents SHALL be retained across reset; unwritten blocks read as X in simulation.

Verification (DELAY=4, BLOCK_SIZE=16, NUM_BLOCKS=256)
REQ-034 Write: index 0x05, din=128'h0123_4567_89AB_CDEF_0011_2233_4455_6677 -> mem_ready low for 5 cycles; no is_output_valid pulse.
REQ-035 Read: then read index 0x05 -> is_output_valid pulses once, 4 edges after acceptance, with dout equal to that din; mem_ready returns to 1 the next cycle.
REQ-036 Wrap and illegal request: write addr=0x105 with din=all ones, then read 0x05 -> all ones; a valid request with mem_read=mem_write=1 -> not accepted, mem_ready stays 1.
REQ-037 Reset mid-write: write index 0x07 = 128'hAA.., assert reset 2 cycles after acceptance, then read 0x07 -> old contents, with 0 when BLOCK_MEM_ZERO_INIT_EN is defined.
REQ-038 Held request: hold a read of 0x05 valid across the response -> a second acceptance occurs the edge after RESP, with identical dout.

Source files
------------

// File: rtl/block_mem_responder.sv
// rtl/block_mem_responder.sv - fixed-latency block memory responder (optional BLOCK_MEM_ZERO_INIT_EN)
module block_mem_responder #(
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_BLOCKS = 256,
    parameter int DELAY      = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_input_valid,
    input  logic [31:0]             addr,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [BLOCK_SIZE*8-1:0] din,
    output logic                    is_output_valid,
    output logic [BLOCK_SIZE*8-1:0] dout,
    output logic                    mem_ready
);

    localparam int         W        = BLOCK_SIZE * 8;
    localparam int         IDX_W    = $clog2(NUM_BLOCKS);
    localparam logic [7:0] CNT_LOAD = 8'(DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_din;
    logic             r_is_write;
    logic             r_out_valid;
    logic [W-1:0]     r_dout;
    logic             r_ready;
    logic [W-1:0]     r_mem [NUM_BLOCKS];

    logic w_accept;
    logic w_commit;
    logic w_unused_addr;

    assign w_accept      = (r_state == S_IDLE) && is_input_valid && (mem_read ^ mem_write);
    assign w_commit      = (r_state == S_RESP) && r_is_write && !reset;
    assign w_unused_addr = ^addr[31:IDX_W];

    assign is_output_valid = r_out_valid;
    assign dout            = r_dout;
    assign mem_ready       = r_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_ready     <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx      <= addr[IDX_W-1:0];
                        r_din      <= din;
                        r_is_write <= mem_write;
                        r_cnt      <= CNT_LOAD;
                        r_ready    <= 1'b0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= S_RESP;
                        // Read data is registered on entry so it is valid for the whole RESP cycle
                        if (!r_is_write) begin
                            r_out_valid <= 1'b1;
                            r_dout      <= r_mem[r_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
`ifdef BLOCK_MEM_ZERO_INIT_EN
        if (reset) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                r_mem[i] <= '0;
            end
        end else
`endif
        if (w_commit) begin
            r_mem[r_idx] <= r_din;
        end
    end

endmodule

// File: tb/tb_block_mem_responder.sv
// tb/tb_block_mem_responder.sv - self-checking bench for block_mem_responder
module tb_block_mem_responder;

    localparam int BS = 16;
    localparam int NB = 256;
    localparam int DL = 4;
    localparam int W  = BS * 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         ivalid;
    logic [31:0]  addr;
    logic         rd;
    logic         wr;
    logic [W-1:0] din;
    logic         ovalid;
    logic [W-1:0] dout;
    logic         ready;

    always #5 clk = ~clk;

    block_mem_responder #(.BLOCK_SIZE(BS), .NUM_BLOCKS(NB), .DELAY(DL)) dut (
        .clk(clk), .reset(reset), .is_input_valid(ivalid), .addr(addr),
        .mem_read(rd), .mem_write(wr), .din(din),
        .is_output_valid(ovalid), .dout(dout), .mem_ready(ready)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] model [NB];
    bit           known [NB];

    typedef struct {
        bit           rd;
        logic [31:0]  addr;
        logic [W-1:0] din;
        logic [W-1:0] exp_dout;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp_v);
        end
    endtask

    function automatic logic [W-1:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_idle();
        ivalid = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        addr   = '0;
        din    = '0;
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
    task automatic txn(input bit r, input logic [31:0] a, input logic [W-1:0] d,
                       input logic [W-1:0] exp_dout, input string name);
        logic [15:0]  rdy_v;
        logic [15:0]  val_v;
        logic [W-1:0] dout_at;
        logic [W-1:0] dout_prev;
        dout_prev = dout;
        chk({name, "_ready_pre"}, W'(ready), W'(1));
        ivalid = 1'b1;
        rd     = r;
        wr     = !r;
        addr   = a;
        din    = d;
        @(posedge clk);
        #1;
        rdy_v   = '0;
        val_v   = '0;
        dout_at = '0;
        for (int k = 1; k <= DL + 2; k++) begin
            @(negedge clk);
            rdy_v[k-1] = ready;
            val_v[k-1] = ovalid;
            if (k == DL + 1) dout_at = dout;
            if (k <= DL) begin
                ivalid = 1'b1;
                rd     = 1'($urandom);
                wr     = 1'($urandom);
                addr   = $urandom;
                din    = rand_blk();
            end else begin
                drive_idle();
            end
        end
        chk({name, "_ready_pattern"}, W'(rdy_v), W'(16'd1 << (DL + 1)));
        chk({name, "_valid_pattern"}, W'(val_v), r ? W'(16'd1 << DL) : W'(0));
        if (r) begin
            chk({name, "_dout"}, dout_at, exp_dout);
            chk({name, "_dout_hold"}, dout, exp_dout);
        end else begin
            chk({name, "_dout_unchanged"}, dout, dout_prev);
            model[a[7:0]] = d;
            known[a[7:0]] = 1'b1;
        end
    endtask

    initial begin
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic [W-1:0] old7;
        int           p0;
        int           p1;
        bit           ill_ok;
        int           idx;
        bit           r;

        for (int i = 0; i < NB; i++) begin
`ifdef BLOCK_MEM_ZERO_INIT_EN
            model[i] = '0;
            known[i] = 1'b1;
`else
            model[i] = '0;
            known[i] = 1'b0;
`endif
        end

        tbl[0] = '{1'b0, 32'h0000_0005, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, '0};
        tbl[1] = '{1'b1, 32'h0000_0005, '0, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677};
        tbl[2] = '{1'b0, 32'h0000_0105, {W{1'b1}}, '0};
        tbl[3] = '{1'b1, 32'h0000_0005, '0, {W{1'b1}}};
        tbl[4] = '{1'b0, 32'h0000_00FF, 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0, '0};
        tbl[5] = '{1'b1, 32'hFFFF_FFFF, '0, 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0};
        tbl[6] = '{1'b0, 32'h0000_0005, 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC, '0};
        tbl[7] = '{1'b1, 32'h0000_0205, '0, 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC};

        reset = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", W'(ready), W'(1));
        chk("reset_valid", W'(ovalid), W'(0));
        chk("reset_dout", dout, '0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            txn(tbl[i].rd, tbl[i].addr, tbl[i].din, tbl[i].exp_dout, $sformatf("vec%0d", i));
        end

        // Both-set and neither-set requests must not be accepted.
        ill_ok = 1'b1;
        ivalid = 1'b1;
        addr   = 32'h5;
        din    = rand_blk();
        for (int c = 0; c < 6; c++) begin
            rd = (c < 3);
            wr = (c < 3);
            @(negedge clk);
            if (ready !== 1'b1 || ovalid !== 1'b0) ill_ok = 1'b0;
        end
        drive_idle();
        chk("illegal_not_accepted", W'(ill_ok), W'(1));
        txn(1'b1, 32'h5, '0, model[5], "illegal_after_read");

        // Reset two cycles into a write must abort it.
        txn(1'b0, 32'h7, 128'h0F0F_0F0F_1111_2222_3333_4444_5555_6666, '0, "pre_abort_write");
        old7   = model[7];
        ivalid = 1'b1;
        wr     = 1'b1;
        addr   = 32'h7;
        din    = {16{8'hAA}};
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`ifdef BLOCK_MEM_ZERO_INIT_EN
        for (int i = 0; i < NB; i++) model[i] = '0;
        old7 = '0;
`endif
        chk("abort_ready", W'(ready), W'(1));
        chk("abort_valid", W'(ovalid), W'(0));
        chk("abort_dout", dout, '0);
        txn(1'b1, 32'h7, '0, old7, "abort_read");

        // Held read is accepted again once the first response completes.
        ivalid = 1'b1;
        rd     = 1'b1;
        wr     = 1'b0;
        addr   = 32'h5;
        p0 = -1;
        p1 = -1;
        d0 = '0;
        d1 = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (ovalid === 1'b1) begin
                if (p0 < 0) begin
                    p0 = c;
                    d0 = dout;
                end else begin
                    p1 = c;
                    d1 = dout;
                    break;
                end
            end
        end
        drive_idle();
        @(negedge clk);
        chk("held_first_latency", W'(p0), W'(DL + 1));
        chk("held_second_gap", W'(p1 - p0), W'(DL + 2));
        chk("held_dout0", d0, model[5]);
        chk("held_dout1", d1, model[5]);
        chk("held_ready_after", W'(ready), W'(1));

        for (int n = 0; n < 40; n++) begin
            idx = int'($urandom_range(0, 15));
            r   = 1'($urandom);
            if (!known[idx]) r = 1'b0;
            txn(r, {24'($urandom), 8'(idx)}, rand_blk(), model[idx], $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
